// File: rtl/weight_bram_fetch_pkg.sv
// weight_bram_fetch_pkg: state encoding and word-width derivation
// shared by the weight fetch engine and its output FIFO.
package weight_bram_fetch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2
   } fetch_state_e;

   function automatic int calc_dw(input int mac_num, input int weight_bits);
      return mac_num * weight_bits;
   endfunction

endpackage

// File: rtl/weight_fetch_fifo.sv
// weight_fetch_fifo: circular buffer accepting up to NPUSH words per
// cycle (lowest slice first) and releasing one word per cycle.
module weight_fetch_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 8,
   parameter int NPUSH = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         flush,
   input  logic [$clog2(NPUSH+1)-1:0]   push_cnt,
   input  logic [NPUSH*W-1:0]           push_data,
   input  logic                         pop,
   output logic [W-1:0]                 head,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(NPUSH + 1);

   logic [W-1:0]     mem_q [DEPTH];
   logic [W-1:0]     wdata [DEPTH];
   logic [DEPTH-1:0] we;
   logic [AW-1:0]    wr_q, wr_d;
   logic [AW-1:0]    rd_q, rd_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   // Pointer advance modulo DEPTH; k never exceeds DEPTH.
   function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] p,
                                              input int unsigned k);
      int unsigned s;
      s = 32'(p) + k;
      if (s >= DEPTH)
         s = s - DEPTH;
      return AW'(s);
   endfunction

   // Scatter the pushed words into consecutive slots and step pointers.
   always_comb begin
      we = '0;
      for (int i = 0; i < DEPTH; i++)
         wdata[i] = '0;
      for (int k = 0; k < NPUSH; k++) begin
         if (PW'(k) < push_cnt) begin
            we[wrap_add(wr_q, k)]    = 1'b1;
            wdata[wrap_add(wr_q, k)] = push_data[k*W +: W];
         end
      end
      wr_d  = wrap_add(wr_q, 32'(push_cnt));
      rd_d  = pop ? wrap_add(rd_q, 1) : rd_q;
      cnt_d = cnt_q + CW'(push_cnt) - CW'(pop);
      if (flush) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   // Storage array; contents are meaningless until counted in.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++)
         if (we[i])
            mem_q[i] <= wdata[i];
   end

   assign head  = mem_q[rd_q];
   assign count = cnt_q;
   assign empty = (cnt_q == '0);

endmodule

// File: rtl/weight_bram_fetch.sv
// weight_bram_fetch: streams a run of BRAM weight words through
// NUM_PORTS parallel read ports into a credit-limited output FIFO.
module weight_bram_fetch
   import weight_bram_fetch_pkg::*;
#(
   parameter int MAC_NUM     = 256,
   parameter int WEIGHT_BITS = 5,
   parameter int NUM_PORTS   = 2,
   parameter int ADDR_W      = 12,
   parameter int RD_LAT      = 1,
   parameter int FIFO_DEPTH  = 8,
   parameter int CNT_W       = 16
) (
   input  logic                                          clk,
   input  logic                                          rst_n,
   input  logic                                          start,
   input  logic [ADDR_W-1:0]                             base_addr,
   input  logic [CNT_W-1:0]                              word_count,
   input  logic                                          abort,
   output logic [NUM_PORTS*ADDR_W-1:0]                   bram_addr,
   output logic [NUM_PORTS-1:0]                          bram_en,
   input  logic [NUM_PORTS*calc_dw(MAC_NUM,WEIGHT_BITS)-1:0] bram_rdata,
   output logic [calc_dw(MAC_NUM,WEIGHT_BITS)-1:0]       out_data,
   output logic                                          out_valid,
   input  logic                                          out_ready,
   output logic                                          out_last,
   output logic                                          busy,
   output logic                                          done
);

   localparam int DW = calc_dw(MAC_NUM, WEIGHT_BITS);
   localparam int LW = DW + 1;
   localparam int NW = $clog2(NUM_PORTS + 1);
   localparam int FW = $clog2(FIFO_DEPTH + 1);
   localparam int SW = FW + 1;

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] cur_q, cur_d;
   logic [CNT_W-1:0]  rem_q, rem_d;
   logic              done_q, done_d;
   logic [NW-1:0]     pcnt_q [RD_LAT];
   logic [NW-1:0]     pcnt_d [RD_LAT];
   logic [RD_LAT-1:0] plast_q, plast_d;

   logic [SW-1:0]     inflight;
   logic [SW-1:0]     used;
   logic [NW-1:0]     n_issue;
   logic [NW-1:0]     push_cnt;
   logic              issue;
   logic              final_issue;
   logic              kill;
   logic              xfer;
   logic [NUM_PORTS*LW-1:0] push_data;
   logic [LW-1:0]     head;
   logic [FW-1:0]     fifo_cnt;
   logic              fifo_empty;

   assign kill = abort && (state_q != ST_IDLE);

   // Credit check against buffered plus in-flight words; drive read ports.
   always_comb begin
      inflight = '0;
      for (int s = 0; s < RD_LAT; s++)
         inflight = inflight + SW'(pcnt_q[s]);
      used = SW'(fifo_cnt) + inflight;
      if (rem_q >= CNT_W'(NUM_PORTS))
         n_issue = NW'(NUM_PORTS);
      else
         n_issue = rem_q[NW-1:0];
      issue = (state_q == ST_FETCH) && !abort &&
              (used <= SW'(FIFO_DEPTH - NUM_PORTS));
      final_issue = issue && (rem_q == CNT_W'(n_issue));
      bram_en   = '0;
      bram_addr = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         if (issue && (NW'(k) < n_issue)) begin
            bram_en[k] = 1'b1;
            bram_addr[k*ADDR_W +: ADDR_W] = cur_q + ADDR_W'(k);
         end
      end
   end

   // Read-latency tracker: word count per stage and end-of-job marker.
   always_comb begin
      pcnt_d[0]  = issue ? n_issue : '0;
      plast_d[0] = final_issue;
      for (int s = 1; s < RD_LAT; s++) begin
         pcnt_d[s]  = pcnt_q[s-1];
         plast_d[s] = plast_q[s-1];
      end
      if (kill) begin
         for (int s = 0; s < RD_LAT; s++)
            pcnt_d[s] = '0;
         plast_d = '0;
      end
   end

   // Returning words carry a last flag on the job's final word.
   always_comb begin
      push_cnt = kill ? '0 : pcnt_q[RD_LAT-1];
      for (int k = 0; k < NUM_PORTS; k++)
         push_data[k*LW +: LW] = {
            plast_q[RD_LAT-1] &&
               (NW'(k) == pcnt_q[RD_LAT-1] - NW'(1)),
            bram_rdata[k*DW +: DW]};
   end

   // Job sequencing: accept, issue, drain to the last transfer.
   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      rem_d   = rem_q;
      done_d  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start && !abort) begin
               if (word_count == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = ST_FETCH;
                  cur_d   = base_addr;
                  rem_d   = word_count;
               end
            end
         end
         ST_FETCH: begin
            if (issue) begin
               cur_d = cur_q + ADDR_W'(n_issue);
               rem_d = rem_q - CNT_W'(n_issue);
               if (final_issue)
                  state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (xfer && out_last) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (kill) begin
         state_d = ST_IDLE;
         done_d  = 1'b0;
      end
   end

   // Control and tracker registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cur_q   <= '0;
         rem_q   <= '0;
         done_q  <= 1'b0;
         plast_q <= '0;
         for (int s = 0; s < RD_LAT; s++)
            pcnt_q[s] <= '0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         rem_q   <= rem_d;
         done_q  <= done_d;
         plast_q <= plast_d;
         pcnt_q  <= pcnt_d;
      end
   end

   weight_fetch_fifo #(
      .W     (LW),
      .DEPTH (FIFO_DEPTH),
      .NPUSH (NUM_PORTS)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (kill),
      .push_cnt  (push_cnt),
      .push_data (push_data),
      .pop       (xfer),
      .head      (head),
      .count     (fifo_cnt),
      .empty     (fifo_empty)
   );

   assign out_valid = !fifo_empty;
   assign xfer      = out_valid && out_ready;
   assign out_data  = head[DW-1:0];
   assign out_last  = out_valid && head[DW];
   assign busy      = (state_q != ST_IDLE);
   assign done      = done_q;

endmodule

// File: tb/tb_weight_bram_fetch.sv
// tb_weight_bram_fetch: directed checks on a 2-port RD_LAT=1 instance
// and a 4-port RD_LAT=3 instance, each fed by a behavioural BRAM.
module tb_weight_bram_fetch;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errs   = 0;
   int checks = 0;

   logic        a_start, a_abort, a_ready;
   logic [11:0] a_base;
   logic [15:0] a_cnt;
   logic [23:0] a_bram_addr;
   logic [1:0]  a_bram_en;
   logic [39:0] a_rdata;
   logic [19:0] a_out_data;
   logic        a_out_valid, a_out_last, a_busy, a_done;

   logic        b_start, b_abort, b_ready;
   logic [11:0] b_base;
   logic [15:0] b_cnt;
   logic [47:0] b_bram_addr;
   logic [3:0]  b_bram_en;
   logic [79:0] b_p0, b_p1, b_rdata;
   logic [19:0] b_out_data;
   logic        b_out_valid, b_out_last, b_busy, b_done;

   weight_bram_fetch #(
      .MAC_NUM(4), .WEIGHT_BITS(5), .NUM_PORTS(2), .ADDR_W(12),
      .RD_LAT(1), .FIFO_DEPTH(8), .CNT_W(16)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .start(a_start), .base_addr(a_base),
      .word_count(a_cnt), .abort(a_abort), .bram_addr(a_bram_addr),
      .bram_en(a_bram_en), .bram_rdata(a_rdata), .out_data(a_out_data),
      .out_valid(a_out_valid), .out_ready(a_ready), .out_last(a_out_last),
      .busy(a_busy), .done(a_done)
   );

   weight_bram_fetch #(
      .MAC_NUM(4), .WEIGHT_BITS(5), .NUM_PORTS(4), .ADDR_W(12),
      .RD_LAT(3), .FIFO_DEPTH(16), .CNT_W(16)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .start(b_start), .base_addr(b_base),
      .word_count(b_cnt), .abort(b_abort), .bram_addr(b_bram_addr),
      .bram_en(b_bram_en), .bram_rdata(b_rdata), .out_data(b_out_data),
      .out_valid(b_out_valid), .out_ready(b_ready), .out_last(b_out_last),
      .busy(b_busy), .done(b_done)
   );

   function automatic logic [19:0] wdat(input logic [11:0] a);
      return {8'hC3, a};
   endfunction

   // Behavioural BRAMs: content is a function of the address.
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++)
         a_rdata[k*20 +: 20] <= a_bram_en[k] ?
            wdat(a_bram_addr[k*12 +: 12]) : 20'hFFFFF;
      for (int k = 0; k < 4; k++)
         b_p0[k*20 +: 20] <= b_bram_en[k] ?
            wdat(b_bram_addr[k*12 +: 12]) : 20'hFFFFF;
      b_p1    <= b_p0;
      b_rdata <= b_p1;
   end

   logic [19:0] a_iss_q[$], a_dat_q[$], b_iss_q[$], b_dat_q[$];
   logic [3:0]  a_en_q[$], b_en_q[$];
   bit          a_last_q[$], b_last_q[$];
   int a_outst, a_max, a_done_cnt, a_last_cyc, a_done_cyc;
   int b_done_cnt;

   // Record issues, transfers, done pulses and buffered-word high water.
   always @(negedge clk) begin
      int ni;
      if (rst_n) begin
         ni = 0;
         for (int k = 0; k < 2; k++)
            if (a_bram_en[k]) begin
               a_iss_q.push_back({8'h00, a_bram_addr[k*12 +: 12]});
               ni++;
            end
         if (a_bram_en != 2'b00) a_en_q.push_back(4'(a_bram_en));
         a_outst = a_outst + ni;
         if (a_out_valid && a_ready) begin
            a_dat_q.push_back(a_out_data);
            a_last_q.push_back(a_out_last);
            a_outst = a_outst - 1;
            if (a_out_last) a_last_cyc = cyc;
         end
         if (a_outst > a_max) a_max = a_outst;
         if (a_done) begin
            a_done_cnt++;
            a_done_cyc = cyc;
         end
         for (int k = 0; k < 4; k++)
            if (b_bram_en[k])
               b_iss_q.push_back({8'h00, b_bram_addr[k*12 +: 12]});
         if (b_bram_en != 4'h0) b_en_q.push_back(b_bram_en);
         if (b_out_valid && b_ready) begin
            b_dat_q.push_back(b_out_data);
            b_last_q.push_back(b_out_last);
         end
         if (b_done) b_done_cnt++;
      end
   end

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errs++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_seq(input string tag, input logic [19:0] q[$],
                          input logic [11:0] base, input int n,
                          input bit is_dat);
      logic [19:0] e;
      check({tag, "_len"}, 64'(q.size()), 64'(n));
      for (int i = 0; i < n && i < q.size(); i++) begin
         e = is_dat ? wdat(base + 12'(i)) : {8'h00, base + 12'(i)};
         check(tag, q[i], e);
      end
   endtask

   task automatic chk_last(input string tag, input bit q[$], input int n);
      logic [63:0] lv;
      lv = '0;
      for (int i = 0; i < q.size() && i < 64; i++) lv[i] = q[i];
      check(tag, lv, 64'd1 << (n - 1));
   endtask

   task automatic clr();
      a_iss_q.delete(); a_dat_q.delete(); a_en_q.delete(); a_last_q.delete();
      b_iss_q.delete(); b_dat_q.delete(); b_en_q.delete(); b_last_q.delete();
      a_outst = 0; a_max = 0; a_done_cnt = 0;
      a_last_cyc = 0; a_done_cyc = 0; b_done_cnt = 0;
   endtask

   task automatic a_go(input logic [11:0] base, input logic [15:0] cnt);
      a_base = base; a_cnt = cnt; a_start = 1'b1;
      tick();
      a_start = 1'b0;
   endtask

   task automatic a_wait(input string tag, input int lim);
      int n = 0;
      while (!a_done && n < lim) begin tick(); n++; end
      check(tag, 64'(a_done), 64'd1);
   endtask

   initial begin
      int n;
      rst_n = 1'b0;
      a_start = 0; a_abort = 0; a_ready = 0; a_base = 0; a_cnt = 0;
      b_start = 0; b_abort = 0; b_ready = 0; b_base = 0; b_cnt = 0;
      clr();
      repeat (3) tick();
      check("rst_en", {a_bram_en, b_bram_en}, 6'h00);
      check("rst_a_addr", a_bram_addr, 24'h0);
      check("rst_b_addr", b_bram_addr, 48'h0);
      check("rst_flags", {a_out_valid, a_out_last, a_busy, a_done,
                          b_out_valid, b_out_last, b_busy, b_done}, 8'h00);
      rst_n = 1'b1;
      repeat (2) tick();

      // basic 5-word job on two ports, with an ignored start while busy
      clr(); a_ready = 1;
      a_go(12'h010, 16'd5);
      check("t1_en0", a_bram_en, 2'b11);
      check("t1_addr0", a_bram_addr, {12'h011, 12'h010});
      check("t1_busy", a_busy, 1'b1);
      a_base = 12'h300; a_cnt = 16'd3; a_start = 1'b1;
      tick();
      a_start = 1'b0;
      check("t1_valid_t2", a_out_valid, 1'b0);
      tick();
      check("t1_valid_t3", a_out_valid, 1'b1);
      check("t1_data_t3", a_out_data, wdat(12'h010));
      a_wait("t1_done", 40);
      repeat (3) tick();
      check("t1_done_cnt", 64'(a_done_cnt), 64'd1);
      check("t1_done_lag", 64'(a_done_cyc - a_last_cyc), 64'd1);
      check("t1_en_len", 64'(a_en_q.size()), 64'd3);
      check("t1_en_p0", a_en_q[0], 4'h3);
      check("t1_en_p1", a_en_q[1], 4'h3);
      check("t1_en_p2", a_en_q[2], 4'h1);
      chk_seq("t1_addr", a_iss_q, 12'h010, 5, 1'b0);
      chk_seq("t1_data", a_dat_q, 12'h010, 5, 1'b1);
      chk_last("t1_last", a_last_q, 5);
      check("t1_idle", a_busy, 1'b0);

      // address wrap across the top of the BRAM
      clr();
      a_go(12'hFFE, 16'd4);
      a_wait("t2_done", 40);
      tick();
      chk_seq("t2_addr", a_iss_q, 12'hFFE, 4, 1'b0);
      chk_seq("t2_data", a_dat_q, 12'hFFE, 4, 1'b1);
      chk_last("t2_last", a_last_q, 4);

      // back-pressure: issue stops at FIFO_DEPTH buffered words
      clr(); a_ready = 0;
      a_go(12'h040, 16'd32);
      repeat (20) tick();
      check("t3_issued", 64'(a_iss_q.size()), 64'd8);
      check("t3_max", 64'(a_max), 64'd8);
      check("t3_en_stall", a_bram_en, 2'b00);
      check("t3_valid", a_out_valid, 1'b1);
      check("t3_hold", a_out_data, wdat(12'h040));
      a_ready = 1;
      a_wait("t3_done", 200);
      tick();
      check("t3_max_end", 64'(a_max), 64'd8);
      chk_seq("t3_data", a_dat_q, 12'h040, 32, 1'b1);
      chk_last("t3_last", a_last_q, 32);

      // zero-length job
      clr();
      a_go(12'h123, 16'd0);
      check("t4_done", a_done, 1'b1);
      check("t4_busy", a_busy, 1'b0);
      check("t4_en", a_bram_en, 2'b00);
      tick();
      check("t4_done_pulse", a_done, 1'b0);
      check("t4_issues", 64'(a_iss_q.size()), 64'd0);

      // start and abort together: abort wins
      clr();
      a_base = 12'h050; a_cnt = 16'd0; a_start = 1; a_abort = 1;
      tick();
      a_start = 0; a_abort = 0;
      check("t5_busy", a_busy, 1'b0);
      check("t5_done", a_done, 1'b0);
      tick();
      check("t5_busy2", a_busy, 1'b0);

      // abort after three words delivered, then a fresh job
      clr(); a_ready = 1;
      a_go(12'h200, 16'd16);
      n = 0;
      while (a_dat_q.size() < 3 && n < 50) begin tick(); n++; end
      check("t6_three", 64'(a_dat_q.size()), 64'd3);
      a_ready = 0; a_abort = 1;
      tick();
      a_abort = 0;
      check("t6_busy", a_busy, 1'b0);
      check("t6_valid", a_out_valid, 1'b0);
      check("t6_en", a_bram_en, 2'b00);
      a_ready = 1;
      repeat (10) tick();
      check("t6_no_stale", 64'(a_dat_q.size()), 64'd3);
      check("t6_no_done", 64'(a_done_cnt), 64'd0);
      clr();
      a_go(12'h100, 16'd4);
      a_wait("t6_done", 40);
      tick();
      chk_seq("t6_data", a_dat_q, 12'h100, 4, 1'b1);
      check("t6_done_cnt", 64'(a_done_cnt), 64'd1);

      // four ports, three-cycle read latency
      clr(); b_ready = 1;
      b_base = 12'h020; b_cnt = 16'd9; b_start = 1;
      tick();
      b_start = 0;
      check("t7_en0", b_bram_en, 4'hF);
      check("t7_addr0", b_bram_addr,
            {12'h023, 12'h022, 12'h021, 12'h020});
      repeat (3) tick();
      check("t7_valid_t4", b_out_valid, 1'b0);
      tick();
      check("t7_valid_t5", b_out_valid, 1'b1);
      check("t7_data_t5", b_out_data, wdat(12'h020));
      n = 0;
      while (!b_done && n < 40) begin tick(); n++; end
      check("t7_done", b_done, 1'b1);
      repeat (2) tick();
      check("t7_done_cnt", 64'(b_done_cnt), 64'd1);
      check("t7_en_len", 64'(b_en_q.size()), 64'd3);
      check("t7_en_p2", b_en_q[2], 4'h1);
      chk_seq("t7_addr", b_iss_q, 12'h020, 9, 1'b0);
      chk_seq("t7_data", b_dat_q, 12'h020, 9, 1'b1);
      chk_last("t7_last", b_last_q, 9);

      // reset in the middle of a job
      clr(); a_ready = 1;
      a_go(12'h300, 16'd16);
      repeat (3) tick();
      rst_n = 0;
      #1;
      check("t8_rst_busy", a_busy, 1'b0);
      check("t8_rst_en", a_bram_en, 2'b00);
      check("t8_rst_valid", a_out_valid, 1'b0);
      tick();
      rst_n = 1;
      repeat (10) tick();
      check("t8_no_done", 64'(a_done_cnt), 64'd0);
      check("t8_valid", a_out_valid, 1'b0);
      check("t8_busy", a_busy, 1'b0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
